// File: rtl/bout_referee_pkg.sv
// rtl/bout_referee_pkg.sv - phase and winner encodings shared by the bout referee
`timescale 1ns/1ps
package bout_referee_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        COUNTDOWN  = 3'd1,
        FENCE      = 3'd2,
        HOLD       = 3'd3,
        MATCH_OVER = 3'd4
    } phase_t;

    localparam logic [1:0] WIN_NONE     = 2'b00;
    localparam logic [1:0] WIN_PLAYER   = 2'b01;
    localparam logic [1:0] WIN_OPPONENT = 2'b10;
    localparam logic [1:0] WIN_DRAW     = 2'b11;

    localparam logic [3:0] TOUCH_MAX = 4'd15;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == TOUCH_MAX) ? v : v + 4'd1;
    endfunction

    function automatic logic [1:0] decide_winner(input logic [3:0] p, input logic [3:0] o);
        if (p > o) begin
            return WIN_PLAYER;
        end else if (o > p) begin
            return WIN_OPPONENT;
        end
        return WIN_DRAW;
    endfunction

endpackage

// File: rtl/bout_referee_frame_timer.sv
// rtl/bout_referee_frame_timer.sv - loadable 16-bit frame down-counter with freeze and save/restore
`timescale 1ns/1ps
module frame_timer (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic [15:0] load_val_i,
    input  logic        freeze_i,
    input  logic        tick_i,
    input  logic        save_i,
    input  logic        restore_i,
    output logic [15:0] value_o,
    output logic [15:0] value_next_o,
    output logic        is_zero_o
);

    logic [15:0] value_q;
    logic [15:0] value_d;
    logic [15:0] saved_q;

    // Load beats restore beats decrement; the counter parks at zero.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (restore_i) begin
            value_d = saved_q;
        end else if (tick_i && !freeze_i && (value_q != 16'd0)) begin
            value_d = value_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            value_q <= 16'd0;
            saved_q <= 16'd0;
        end else begin
            value_q <= value_d;
            if (save_i) begin
                saved_q <= value_d;
            end
        end
    end

    assign value_o      = value_q;
    assign value_next_o = value_d;
    assign is_zero_o    = (value_q == 16'd0);

endmodule

// File: rtl/bout_referee.sv
// rtl/bout_referee.sv - bout sequencer: countdown, fencing, post-touch hold, touch scoring, winner
`timescale 1ns/1ps
module bout_referee
    import bout_referee_pkg::*;
#(
    parameter int COUNTDOWN_FRAMES = 180,
    parameter int HOLD_FRAMES      = 90,
    parameter int ROUND_FRAMES     = 5400,
    parameter int TOUCHES_TO_WIN   = 5
) (
    input  logic        clk_pixel_in,
    input  logic        rst_n_in,
    input  logic        new_frame_in,
    input  logic        start_in,
    input  logic        score_valid_in,
    input  logic        player_scored_in,
    input  logic        opponent_scored_in,
    output logic        fencing_enable_out,
    output logic        sync_req_out,
    output logic [2:0]  phase_out,
    output logic [3:0]  player_touches_out,
    output logic [3:0]  opponent_touches_out,
    output logic [15:0] frames_left_out,
    output logic [1:0]  winner_out,
    output logic        match_over_out
);

    localparam logic [15:0] CD_LOAD    = 16'(COUNTDOWN_FRAMES);
    localparam logic [15:0] HOLD_LOAD  = 16'(HOLD_FRAMES);
    localparam logic [15:0] ROUND_LOAD = 16'(ROUND_FRAMES);
    localparam logic [3:0]  WIN_COUNT  = 4'(TOUCHES_TO_WIN);
    localparam logic [3:0]  LAST_TOUCH = 4'(TOUCHES_TO_WIN - 1);

    // Reset asserts asynchronously and releases two clocks later.
    logic [1:0] rst_sync_q;
    logic       rst_core_n;

    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_core_n = rst_sync_q[1];

    phase_t      phase_q, phase_d;
    logic [3:0]  player_q, player_d;
    logic [3:0]  opp_q, opp_d;
    logic [1:0]  winner_q, winner_d;
    logic        sync_q, sync_d;
    logic [15:0] frames_q, frames_d;

    logic        aux_load, aux_freeze, aux_zero;
    logic [15:0] aux_load_val, aux_value, aux_next;
    logic        rnd_load, rnd_freeze, rnd_save, rnd_restore, rnd_zero;
    logic [15:0] rnd_value, rnd_next;

    logic aux_done, rnd_done, score_hit, annul;

    assign aux_done  = new_frame_in && (aux_zero || (aux_value == 16'd1));
    assign rnd_done  = new_frame_in && (rnd_zero || (rnd_value == 16'd1));
    assign score_hit = score_valid_in && (player_scored_in || opponent_scored_in);
    assign annul     = player_scored_in && opponent_scored_in &&
                       (player_q == LAST_TOUCH) && (opp_q == LAST_TOUCH);

    always_comb begin
        phase_d      = phase_q;
        player_d     = player_q;
        opp_d        = opp_q;
        winner_d     = winner_q;
        aux_load     = 1'b0;
        aux_load_val = CD_LOAD;
        rnd_load     = 1'b0;
        case (phase_q)
            IDLE, MATCH_OVER: begin
                if (start_in) begin
                    phase_d  = COUNTDOWN;
                    player_d = 4'd0;
                    opp_d    = 4'd0;
                    winner_d = WIN_NONE;
                    aux_load = 1'b1;
                end
            end
            COUNTDOWN: begin
                if (aux_done) begin
                    phase_d  = FENCE;
                    rnd_load = 1'b1;
                end
            end
            FENCE: begin
                if (score_valid_in && !annul) begin
                    if (player_scored_in) begin
                        player_d = sat_inc(player_q);
                    end
                    if (opponent_scored_in) begin
                        opp_d = sat_inc(opp_q);
                    end
                end
                // Clock expiry wins over the hold so a last-frame touch ends the bout directly.
                if (rnd_done) begin
                    phase_d = MATCH_OVER;
                end else if (score_hit) begin
                    phase_d      = HOLD;
                    aux_load     = 1'b1;
                    aux_load_val = HOLD_LOAD;
                end
            end
            HOLD: begin
                if (aux_done) begin
                    phase_d = ((player_q >= WIN_COUNT) || (opp_q >= WIN_COUNT)) ? MATCH_OVER : FENCE;
                end
            end
            default: phase_d = IDLE;
        endcase
        if ((phase_d == MATCH_OVER) && (phase_q != MATCH_OVER)) begin
            winner_d = decide_winner(player_d, opp_d);
        end
    end

    assign aux_freeze  = !((phase_q == COUNTDOWN) || (phase_q == HOLD));
    assign rnd_freeze  = (phase_q != FENCE);
    assign rnd_save    = (phase_q == FENCE) && (phase_d == HOLD);
    assign rnd_restore = (phase_q == HOLD) && (phase_d == FENCE);
    assign sync_d      = new_frame_in && (phase_q == FENCE);

    // Display follows the timer that will be active next cycle, so it never lags the counter.
    always_comb begin
        frames_d = 16'd0;
        case (phase_d)
            COUNTDOWN, HOLD: frames_d = aux_next;
            FENCE:           frames_d = rnd_next;
            default:         frames_d = 16'd0;
        endcase
    end

    frame_timer u_aux_timer (
        .clk_i        (clk_pixel_in),
        .rst_n_i      (rst_core_n),
        .load_i       (aux_load),
        .load_val_i   (aux_load_val),
        .freeze_i     (aux_freeze),
        .tick_i       (new_frame_in),
        .save_i       (1'b0),
        .restore_i    (1'b0),
        .value_o      (aux_value),
        .value_next_o (aux_next),
        .is_zero_o    (aux_zero)
    );

    frame_timer u_round_timer (
        .clk_i        (clk_pixel_in),
        .rst_n_i      (rst_core_n),
        .load_i       (rnd_load),
        .load_val_i   (ROUND_LOAD),
        .freeze_i     (rnd_freeze),
        .tick_i       (new_frame_in),
        .save_i       (rnd_save),
        .restore_i    (rnd_restore),
        .value_o      (rnd_value),
        .value_next_o (rnd_next),
        .is_zero_o    (rnd_zero)
    );

    always_ff @(posedge clk_pixel_in or negedge rst_core_n) begin
        if (!rst_core_n) begin
            phase_q  <= IDLE;
            player_q <= 4'd0;
            opp_q    <= 4'd0;
            winner_q <= WIN_NONE;
            sync_q   <= 1'b0;
            frames_q <= 16'd0;
        end else begin
            phase_q  <= phase_d;
            player_q <= player_d;
            opp_q    <= opp_d;
            winner_q <= winner_d;
            sync_q   <= sync_d;
            frames_q <= frames_d;
        end
    end

    assign phase_out            = phase_q;
    assign fencing_enable_out   = (phase_q == FENCE);
    assign match_over_out       = (phase_q == MATCH_OVER);
    assign sync_req_out         = sync_q;
    assign player_touches_out   = player_q;
    assign opponent_touches_out = opp_q;
    assign frames_left_out      = frames_q;
    assign winner_out           = winner_q;

endmodule

// File: tb/tb_bout_referee.sv
// tb/tb_bout_referee.sv - scoreboard bench for the bout referee
`timescale 1ns/1ps
module tb_bout_referee;

    localparam int CD = 3;
    localparam int HF = 2;
    localparam int RF = 20;
    localparam int TW = 2;

    localparam int O_PHASE = 0;
    localparam int O_PT    = 1;
    localparam int O_OT    = 2;
    localparam int O_FL    = 3;
    localparam int O_WIN   = 4;
    localparam int O_MO    = 5;
    localparam int O_FEN   = 6;
    localparam int O_SYNC  = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        new_frame = 1'b0;
    logic        start = 1'b0;
    logic        sv = 1'b0;
    logic        ps = 1'b0;
    logic        os = 1'b0;
    logic        fen, sync_req, mo;
    logic [2:0]  phase;
    logic [3:0]  pt, ot;
    logic [15:0] fl;
    logic [1:0]  win;

    always #5 clk = ~clk;

    bout_referee #(
        .COUNTDOWN_FRAMES (CD),
        .HOLD_FRAMES      (HF),
        .ROUND_FRAMES     (RF),
        .TOUCHES_TO_WIN   (TW)
    ) dut (
        .clk_pixel_in         (clk),
        .rst_n_in             (rst_n),
        .new_frame_in         (new_frame),
        .start_in             (start),
        .score_valid_in       (sv),
        .player_scored_in     (ps),
        .opponent_scored_in   (os),
        .fencing_enable_out   (fen),
        .sync_req_out         (sync_req),
        .phase_out            (phase),
        .player_touches_out   (pt),
        .opponent_touches_out (ot),
        .frames_left_out      (fl),
        .winner_out           (win),
        .match_over_out       (mo)
    );

    typedef struct {
        string tag;
        int    sel;
        int    exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            O_PHASE: return {29'd0, phase};
            O_PT:    return {28'd0, pt};
            O_OT:    return {28'd0, ot};
            O_FL:    return {16'd0, fl};
            O_WIN:   return {30'd0, win};
            O_MO:    return {31'd0, mo};
            O_FEN:   return {31'd0, fen};
            default: return {31'd0, sync_req};
        endcase
    endfunction

    task automatic expect_out(input string tag, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = val;
        sb_q.push_back(e);
    endtask

    task automatic exp_core(input string tag, input int ph, input int p, input int o, input int f);
        expect_out({tag, ".phase"}, O_PHASE, ph);
        expect_out({tag, ".player"}, O_PT, p);
        expect_out({tag, ".opponent"}, O_OT, o);
        expect_out({tag, ".frames"}, O_FL, f);
    endtask

    task automatic exp_result(input string tag, input int w, input int m, input int e);
        expect_out({tag, ".winner"}, O_WIN, w);
        expect_out({tag, ".match_over"}, O_MO, m);
        expect_out({tag, ".fence_en"}, O_FEN, e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
        new_frame = 1'b0;
        start     = 1'b0;
        sv        = 1'b0;
        ps        = 1'b0;
        os        = 1'b0;
    endtask

    task automatic frame(input string tag, input int ph, input int p, input int o, input int f);
        new_frame = 1'b1;
        exp_core(tag, ph, p, o, f);
        tick();
        tick();
    endtask

    task automatic run_countdown(input string tag);
        start = 1'b1;
        exp_core({tag, ".start"}, 1, 0, 0, CD);
        exp_result({tag, ".start"}, 0, 0, 0);
        tick();
        frame({tag, ".cd1"}, 1, 0, 0, 2);
        frame({tag, ".cd2"}, 1, 0, 0, 1);
        new_frame = 1'b1;
        exp_core({tag, ".cd3"}, 2, 0, 0, RF);
        expect_out({tag, ".cd3.fence_en"}, O_FEN, 1);
        expect_out({tag, ".cd3.sync"}, O_SYNC, 0);
        tick();
        tick();
    endtask

    initial begin
        tick();
        exp_core("reset", 0, 0, 0, 0);
        exp_result("reset", 0, 0, 0);
        expect_out("reset.sync", O_SYNC, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out("post_reset.phase", O_PHASE, 0);
            tick();
        end

        run_countdown("bout1");
        for (int i = 1; i <= 3; i++) begin
            new_frame = 1'b1;
            exp_core("fence_frame", 2, 0, 0, RF - i);
            expect_out("fence_frame.sync", O_SYNC, 1);
            tick();
            expect_out("fence_idle.sync", O_SYNC, 0);
            tick();
        end

        sv = 1'b1; ps = 1'b1;
        exp_core("touch_p", 3, 1, 0, HF);
        expect_out("touch_p.fence_en", O_FEN, 0);
        tick();
        frame("hold1", 3, 1, 0, 1);
        new_frame = 1'b1;
        exp_core("hold_end", 2, 1, 0, 17);
        expect_out("hold_end.fence_en", O_FEN, 1);
        tick();
        tick();
        frame("resume", 2, 1, 0, 16);

        start = 1'b1;
        exp_core("start_in_fence", 2, 1, 0, 16);
        tick();
        ps = 1'b1; os = 1'b1;
        exp_core("no_valid", 2, 1, 0, 16);
        tick();

        sv = 1'b1; os = 1'b1;
        exp_core("touch_o", 3, 1, 1, HF);
        tick();
        sv = 1'b1; ps = 1'b1;
        exp_core("score_in_hold", 3, 1, 1, HF);
        tick();
        frame("hold2a", 3, 1, 1, 1);
        frame("hold2b", 2, 1, 1, 16);

        sv = 1'b1; ps = 1'b1; os = 1'b1;
        exp_core("double_annul", 3, 1, 1, HF);
        tick();
        frame("hold3a", 3, 1, 1, 1);
        frame("hold3b", 2, 1, 1, 16);

        sv = 1'b1; os = 1'b1;
        exp_core("touch_o_win", 3, 1, 2, HF);
        tick();
        frame("hold4a", 3, 1, 2, 1);
        new_frame = 1'b1;
        exp_core("opp_wins", 4, 1, 2, 0);
        exp_result("opp_wins", 2, 1, 0);
        tick();

        start = 1'b1;
        exp_core("restart", 1, 0, 0, CD);
        exp_result("restart", 0, 0, 0);
        tick();
        sv = 1'b1; ps = 1'b1;
        exp_core("score_in_countdown", 1, 0, 0, CD);
        tick();
        frame("bout2.cd1", 1, 0, 0, 2);
        frame("bout2.cd2", 1, 0, 0, 1);
        frame("bout2.cd3", 2, 0, 0, RF);
        for (int i = 1; i < RF; i++) begin
            frame("timeout_run", 2, 0, 0, RF - i);
        end
        new_frame = 1'b1;
        exp_core("timeout", 4, 0, 0, 0);
        exp_result("timeout", 3, 1, 0);
        tick();

        run_countdown("bout3");
        for (int i = 1; i < RF; i++) begin
            frame("expiry_run", 2, 0, 0, RF - i);
        end
        new_frame = 1'b1; sv = 1'b1; ps = 1'b1;
        exp_core("touch_at_expiry", 4, 1, 0, 0);
        exp_result("touch_at_expiry", 1, 1, 0);
        tick();

        run_countdown("bout4");
        sv = 1'b1; ps = 1'b1;
        exp_core("bout4.touch", 3, 1, 0, HF);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        exp_core("async_reset", 0, 0, 0, 0);
        exp_result("async_reset", 0, 0, 0);
        expect_out("async_reset.sync", O_SYNC, 0);
        drain();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_core("after_reset", 0, 0, 0, 0);
            tick();
        end
        start = 1'b1;
        exp_core("start_after_reset", 1, 0, 0, CD);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
